apb_norflash_bridge: RTL
========================

// Module: apb_norflash_bridge
// PURPOSE
//   APB3 slave front-end directly upstream of the norflash engine. Turns APB register accesses into
//   single byte read/program requests on a req/ack command port into the engine, and captures the read
//   byte. Adds a status register, a sticky done/timeout pair and a level interrupt.
// PARAMETERS
//   ADDR_W       8     flash byte address width (fl_addr, ADDR register)
//   DATA_W       8     flash data width (fl_wdata, fl_rdata, WDATA/RDATA registers)
//   TIMEOUT_CYC  1024  sys_clk cycles in BUSY without fl_ack before abort; must be >= 2
// PORTS
//   sys_clk    in   1       single clock, all logic on rising edge
//   sys_rst_n  in   1       reset, synchronous, active-low
//   psel       in   1       APB select
//   penable    in   1       APB enable (access phase)
//   pwrite     in   1       1=write, 0=read
//   paddr      in   5       byte address; [1:0] ignored
//   pwdata     in   32      write data
//   prdata     out  32      read data, valid in access phase
//   pready     out  1       constant 1 (zero wait states)
//   pslverr    out  1       error response, access phase only
//   fl_req     out  1       command request to norflash engine
//   fl_we      out  1       1=program byte, 0=read byte; stable while fl_req=1
//   fl_addr    out  ADDR_W  flash address; stable while fl_req=1
//   fl_wdata   out  DATA_W  program data; stable while fl_req=1
//   fl_ack     in   1       one-cycle completion pulse from engine
//   fl_rdata   in   DATA_W  read byte, valid in the fl_ack cycle
//   irq        out  1       level interrupt = IE & (DONE | TIMEOUT)
// BEHAVIOUR
//   Reset (sys_rst_n=0 at a rising edge): all registers 0, FSM=IDLE, fl_req=0, fl_we=0, fl_addr=0,
//     fl_wdata=0, prdata=0, pslverr=0, irq=0. Reset mid-operation drops fl_req the next edge, no DONE.
//   APB: a write commits on the edge where psel&penable&pwrite; reads are combinational from registers.
//   Register map (paddr[4:2]):
//     0 CTRL   W:  [0]START (self-clearing, reads 0), [1]WR (1=program), [2]IE (reads back)
//     1 ADDR   RW: [ADDR_W-1:0]
//     2 WDATA  RW: [DATA_W-1:0]
//     3 RDATA  RO: [DATA_W-1:0], last captured read byte; writes ignored
//     4 STATUS R: [0]BUSY [1]DONE [2]TIMEOUT; write 1 to [1]/[2] clears that bit (W1C)
//     5-7      unmapped: pslverr=1, reads 0, writes ignored
//   Unused upper bits read 0.
//   FSM IDLE -> BUSY: CTRL write with START=1 while IDLE. On that edge DONE, TIMEOUT cleared and fl_we<=WR.
//     fl_addr<=ADDR and fl_wdata<=WDATA are sampled on the same edge; the timeout counter is zeroed.
//     fl_req=1 from the next cycle.
//   START while BUSY: pslverr=1, request ignored; the IE bit of that write is still updated.
//   ADDR/WDATA writes while BUSY update the registers but not the latched fl_* outputs.
//   BUSY: fl_req held 1; counter increments each cycle without ack.
//     fl_ack=1 -> fl_req<=0, DONE<=1, FSM<=IDLE; for a read, RDATA<=fl_rdata on that edge.
//     If counter reaches TIMEOUT_CYC-1 with no ack -> fl_req<=0, TIMEOUT<=1, FSM<=IDLE; RDATA unchanged.
//     fl_ack in the same cycle as timeout expiry: ack wins (DONE, not TIMEOUT).
//   fl_ack while IDLE is ignored.
//   Latency: START write edge -> fl_req high 1 cycle later; ack edge -> BUSY=0 visible next APB read.
//   W1C on DONE in the same cycle DONE is set: set wins. STATUS read shows BUSY=1 from START edge on.
//   irq is registered, one cycle after DONE/TIMEOUT/IE change.
// TESTING
//   Reset: hold sys_rst_n=0 for 3 clocks -> every output 0, STATUS reads 0x0, pready=1.
//   Read op: ADDR=0x3A, CTRL=0x1; engine acks after 4 cycles with fl_rdata=0xCC
//     -> fl_req high exactly 4 cycles, fl_we=0, fl_addr=0x3A; then RDATA=0xCC, STATUS=0x2.
//   Program op: ADDR=0x10, WDATA=0x5A, CTRL=0x7 (START|WR|IE); ack after 2 cycles
//     -> fl_we=1, fl_wdata=0x5A, STATUS=0x2, irq=1; write STATUS=0x2 -> irq=0 next cycle.
//   Timeout (TIMEOUT_CYC=8): CTRL=0x1, never ack -> fl_req high 8 cycles then 0, STATUS=0x4, RDATA unchanged.
//   Busy collision: second CTRL=0x1 during BUSY -> pslverr=1; ADDR write to 0x77 while BUSY
//     -> fl_addr unchanged until next START.
//   Errors: APB read/write paddr=0x18 -> pslverr=1, prdata=0;
//     ack coincident with timeout expiry -> STATUS=0x2.

Source files
------------

// File: rtl/apb_norflash_bridge_if.sv
// APB3 bus bundle between a CPU-side master and the norflash bridge slave.
// Zero-wait-state slaves tie pready high.
interface apb_norflash_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_norflash_bridge.sv
// APB3 register front-end that issues single-byte read/program commands to the norflash
// engine over a req/ack port, with sticky DONE/TIMEOUT status and a level interrupt.
module apb_norflash_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  apb_norflash_bridge_if.slave apb,
  output logic              fl_req,
  output logic              fl_we,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [DATA_W-1:0] fl_wdata,
  input  logic              fl_ack,
  input  logic [DATA_W-1:0] fl_rdata,
  output logic              irq
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_ADDR   = 3'd1;
  localparam logic [2:0] REG_WDATA  = 3'd2;
  localparam logic [2:0] REG_RDATA  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic              ie;
  logic              done_flag;
  logic              timeout_flag;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [2:0]  sel;
  logic        wr_en;
  logic        start_req;
  logic        launch;
  logic        ack_hit;
  logic        expire;
  logic        busy;
  logic [31:0] prdata_c;
  logic        unused_bits;

  assign sel         = apb.paddr[4:2];
  assign wr_en       = apb.psel & apb.penable & apb.pwrite;
  assign start_req   = wr_en && (sel == REG_CTRL) && apb.pwdata[0];
  assign busy        = (state_q == BUSY);
  assign unused_bits = &{1'b0, apb.paddr[1:0], apb.pwdata};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Ack is checked before the timeout so a completion in the expiry cycle still counts as DONE.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    ack_hit = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          launch  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (fl_ack) begin
          ack_hit = 1'b1;
          state_d = IDLE;
        end else if (cnt == CNT_MAX) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status sets are placed after the W1C clears so a set in the same cycle wins.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ie           <= 1'b0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      cnt          <= '0;
      fl_req       <= 1'b0;
      fl_we        <= 1'b0;
      fl_addr      <= '0;
      fl_wdata     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en) begin
        case (sel)
          REG_CTRL:   ie        <= apb.pwdata[2];
          REG_ADDR:   addr_reg  <= apb.pwdata[ADDR_W-1:0];
          REG_WDATA:  wdata_reg <= apb.pwdata[DATA_W-1:0];
          REG_STATUS: begin
            if (apb.pwdata[1]) done_flag    <= 1'b0;
            if (apb.pwdata[2]) timeout_flag <= 1'b0;
          end
          default: ;
        endcase
      end
      if (launch) begin
        done_flag    <= 1'b0;
        timeout_flag <= 1'b0;
        fl_we        <= apb.pwdata[1];
        fl_addr      <= addr_reg;
        fl_wdata     <= wdata_reg;
        cnt          <= '0;
        fl_req       <= 1'b1;
      end
      if (ack_hit) begin
        fl_req    <= 1'b0;
        done_flag <= 1'b1;
        if (!fl_we) rdata_reg <= fl_rdata;
      end else if (expire) begin
        fl_req       <= 1'b0;
        timeout_flag <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      irq <= ie & (done_flag | timeout_flag);
    end
  end

  always_comb begin
    prdata_c = '0;
    case (sel)
      REG_CTRL:   prdata_c[2]          = ie;
      REG_ADDR:   prdata_c[ADDR_W-1:0] = addr_reg;
      REG_WDATA:  prdata_c[DATA_W-1:0] = wdata_reg;
      REG_RDATA:  prdata_c[DATA_W-1:0] = rdata_reg;
      REG_STATUS: prdata_c[2:0]        = {timeout_flag, done_flag, busy};
      default:    prdata_c             = '0;
    endcase
  end

  assign apb.prdata  = prdata_c;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable &
                       ((sel > REG_STATUS) | (start_req & busy));

endmodule
